btn_debounce: RTL and testbench

Debounces one raw mechanical push-button input and produces the clean, glitch-free level `stable`. That level feeds the team's one-cycle edge/pulse generators. The block also produces a `hold` level that flags a long press, for auto-repeat and mode-change features. One instance is used per board button. It runs entirely in the `clk` domain; `btn_in` is asynchronous to `clk`.

---
 rtl/btn_debounce.sv | 124 ++++++++++++
 tb/tb_btn_debounce.sv | 130 +++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and long-press detector
// stable follows btn_in once it has held a level for DEBOUNCE_CYCLES samples; hold flags a long press.

module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int unsigned HOLD_W          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic stable,
    output logic hold
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state;
    logic                sync_ff1;
    logic                sync_ff2;
    logic                btn_s;
    logic [CNT_W-1:0]    cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                cnt_last;
    logic                stable_fall;

    assign btn_s       = sync_ff2;
    assign cnt_last    = (cnt == CNT_LAST);
    assign stable_fall = (state == S_FALL) && !btn_s && cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= btn_in;
            sync_ff2 <= sync_ff1;
        end
    end

    // Any sample at the old level drops back to the settled state; no partial credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_LOW;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            case (state)
                S_LOW: begin
                    stable <= 1'b0;
                    if (btn_s) begin
                        state <= S_RISE;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_RISE: begin
                    if (!btn_s) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt_last) begin
                        state  <= S_HIGH;
                        stable <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    stable <= 1'b1;
                    if (!btn_s) begin
                        state <= S_FALL;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_FALL: begin
                    if (btn_s) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt_last) begin
                        state  <= S_LOW;
                        stable <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= S_LOW;
                    stable <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Release bounce in S_FALL still counts as pressed; the counter saturates so hold never re-triggers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            hold     <= 1'b0;
        end else if (!stable || stable_fall) begin
            hold_cnt <= '0;
            hold     <= 1'b0;
        end else begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (hold_cnt >= HOLD_PRE) begin
                hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed vector bench for btn_debounce
// One table entry per clock: btn_in captured at that edge and outputs expected just after it.

module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic stable;
    logic hold;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic btn;
        logic exp_stable;
        logic exp_hold;
    } vec_t;

    vec_t vecs[$];

    btn_debounce #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .stable(stable),
        .hold(hold)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic b, input logic s, input logic h, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.btn        = b;
            v.exp_stable = s;
            v.exp_hold   = h;
            vecs.push_back(v);
        end
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic b, input logic es, input logic eh);
        btn_in = b;
        @(posedge clk);
        #1;
        check({tag, " stable"}, stable, es);
        check({tag, " hold"}, hold, eh);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;

        // clean press, hold asserts 15 edges after the first capture
        add(1, 0, 0, 5);
        add(1, 1, 0, 10);
        add(1, 1, 1, 5);
        // 2-cycle release glitch while hold is set
        add(0, 1, 1, 2);
        add(1, 1, 1, 8);
        // clean release: both drop together after edge 5
        add(0, 1, 1, 5);
        add(0, 0, 0, 8);
        // press bounce 1,1,1,0 then a short 7-cycle press
        add(1, 0, 0, 3);
        add(0, 0, 0, 1);
        add(1, 0, 0, 5);
        add(1, 1, 0, 2);
        add(0, 1, 0, 5);
        add(0, 0, 0, 4);
        // next press must count hold from zero
        add(1, 0, 0, 5);
        add(1, 1, 0, 10);
        add(1, 1, 1, 5);

        repeat (2) @(posedge clk);
        #1;
        check("reset stable", stable, 1'b0);
        check("reset hold", hold, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].btn, vecs[i].exp_stable, vecs[i].exp_hold);
        end

        // async reset while stable and hold are both 1
        #3;
        rst = 1'b1;
        #1;
        check("async rst stable", stable, 1'b0);
        check("async rst hold", hold, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset during a rising count with the button still held
        for (int k = 0; k < 3; k++) begin
            step($sformatf("pre_rst e%0d", k), 1'b1, 1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-count rst stable", stable, 1'b0);
        check("mid-count rst hold", hold, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 18; k++) begin
            step($sformatf("post_rst e%0d", k), 1'b1, (k >= 5) ? 1'b1 : 1'b0, (k >= 15) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
